// File: rtl/rvb_share_arbiter.sv
// Round-robin sharing of one bit-manipulation unit between NREQ requesters.
// A tag FIFO remembers who issued each op so results are routed back in issue order.
module rvb_share_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREQ  = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         hold,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ*XLEN-1:0]         req_rs1,
    input  logic [NREQ*XLEN-1:0]         req_rs2,
    input  logic [NREQ*XLEN-1:0]         req_rs3,
    input  logic [NREQ*9-1:0]            req_insn,
    output logic [NREQ-1:0]              rsp_valid,
    input  logic [NREQ-1:0]              rsp_ready,
    output logic [XLEN-1:0]              rsp_rd,
    output logic                         u_din_valid,
    input  logic                         u_din_ready,
    output logic [XLEN-1:0]              u_din_rs1,
    output logic [XLEN-1:0]              u_din_rs2,
    output logic [XLEN-1:0]              u_din_rs3,
    output logic [8:0]                   u_din_insn,
    input  logic                         u_dout_valid,
    output logic                         u_dout_ready,
    input  logic [XLEN-1:0]              u_dout_rd,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic                         err_orphan
);

    localparam int unsigned TW = $clog2(NREQ);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned IW = 9;

    logic [TW-1:0]   r_rr_ptr;
    logic [TW-1:0]   r_tag [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_err_orphan;

    logic [TW-1:0]   w_grant;
    logic            w_any;
    int unsigned     w_idx;
    logic            w_full;
    logic            w_empty;
    logic            w_en;
    logic            w_push;
    logic            w_pop;
    logic [TW-1:0]   w_head;
    logic [XLEN-1:0] w_rs1 [NREQ];
    logic [XLEN-1:0] w_rs2 [NREQ];
    logic [XLEN-1:0] w_rs3 [NREQ];
    logic [IW-1:0]   w_insn [NREQ];

    // Unpack the flat per-requester payload buses.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_rs1[i]  = req_rs1[i*XLEN +: XLEN];
            w_rs2[i]  = req_rs2[i*XLEN +: XLEN];
            w_rs3[i]  = req_rs3[i*XLEN +: XLEN];
            w_insn[i] = req_insn[i*IW +: IW];
        end
    end

    // First valid requester starting at rr_ptr; defaults to rr_ptr when none valid.
    always_comb begin
        w_grant = r_rr_ptr;
        w_any   = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = 32'(r_rr_ptr) + 32'(k);
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_any && req_valid[TW'(w_idx)]) begin
                w_any   = 1'b1;
                w_grant = TW'(w_idx);
            end
        end
    end

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_en    = !hold && !w_full;
    assign w_head  = r_tag[r_rd_ptr];

    assign u_din_valid = w_en && w_any;
    assign u_din_rs1   = w_rs1[w_grant];
    assign u_din_rs2   = w_rs2[w_grant];
    assign u_din_rs3   = w_rs3[w_grant];
    assign u_din_insn  = w_insn[w_grant];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = w_en && u_din_ready && req_valid[i] && (w_grant == TW'(i));
        end
    end

    // Results go to the head-of-FIFO requester; with no tags outstanding they are drained.
    always_comb begin
        rsp_valid = '0;
        if (!w_empty) begin
            rsp_valid[w_head] = u_dout_valid;
        end
    end

    assign u_dout_ready = w_empty ? 1'b1 : rsp_ready[w_head];
    assign rsp_rd       = u_dout_rd;

    assign w_push = u_din_valid && u_din_ready;
    assign w_pop  = !w_empty && u_dout_valid && rsp_ready[w_head];

    assign busy        = !w_empty;
    assign outstanding = r_count;
    assign err_orphan  = r_err_orphan;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rr_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                r_rr_ptr <= (w_grant == TW'(NREQ-1)) ? '0 : w_grant + TW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_empty && u_dout_valid) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_tag[r_wr_ptr] <= w_grant;
        end
    end

endmodule

// File: tb/tb_rvb_share_arbiter.sv
// Directed bench for rvb_share_arbiter (NREQ=3, DEPTH=4); the bench plays the shared unit.
module tb_rvb_share_arbiter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREQ  = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH+1);

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    hold;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*XLEN-1:0]    req_rs1;
    logic [NREQ*XLEN-1:0]    req_rs2;
    logic [NREQ*XLEN-1:0]    req_rs3;
    logic [NREQ*9-1:0]       req_insn;
    logic [NREQ-1:0]         rsp_valid;
    logic [NREQ-1:0]         rsp_ready;
    logic [XLEN-1:0]         rsp_rd;
    logic                    u_din_valid;
    logic                    u_din_ready;
    logic [XLEN-1:0]         u_din_rs1;
    logic [XLEN-1:0]         u_din_rs2;
    logic [XLEN-1:0]         u_din_rs3;
    logic [8:0]              u_din_insn;
    logic                    u_dout_valid;
    logic                    u_dout_ready;
    logic [XLEN-1:0]         u_dout_rd;
    logic                    busy;
    logic [CW-1:0]           outstanding;
    logic                    err_orphan;

    int n_checks = 0;
    int n_errors = 0;

    rvb_share_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3), .req_insn(req_insn),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
        .u_din_valid(u_din_valid), .u_din_ready(u_din_ready),
        .u_din_rs1(u_din_rs1), .u_din_rs2(u_din_rs2), .u_din_rs3(u_din_rs3),
        .u_din_insn(u_din_insn),
        .u_dout_valid(u_dout_valid), .u_dout_ready(u_dout_ready), .u_dout_rd(u_dout_rd),
        .busy(busy), .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1-2 time units after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        hold         = 1'b0;
        req_valid    = '0;
        rsp_ready    = '1;
        u_din_ready  = 1'b1;
        u_dout_valid = 1'b0;
        u_dout_rd    = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_rs1[i*XLEN +: XLEN] = 32'hA000_0000 + 32'(i);
            req_rs2[i*XLEN +: XLEN] = 32'hB000_0000 + 32'(i);
            req_rs3[i*XLEN +: XLEN] = 32'hC000_0000 + 32'(i);
            req_insn[i*9 +: 9]      = 9'h1A0 + 9'(i);
        end

        // Reset state
        step();
        reset = 1'b1;
        #1;
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_busy",        64'(busy),        64'd0);
        check("rst_rsp_valid",   64'(rsp_valid),   64'd0);
        check("rst_req_ready",   64'(req_ready),   64'd0);
        check("rst_din_valid",   64'(u_din_valid), 64'd0);
        check("rst_dout_ready",  64'(u_dout_ready), 64'd1);
        check("rst_err_orphan",  64'(err_orphan),  64'd0);

        // Alternating grants between requesters 0 and 1, results routed back in order
        req_valid = 3'b011;
        #1;
        check("alt1_ready", 64'(req_ready), 64'b001);
        check("alt1_rs1",   64'(u_din_rs1), 64'hA000_0000);
        check("alt1_insn",  64'(u_din_insn), 64'h1A0);
        step();
        u_dout_valid = 1'b1; u_dout_rd = 32'h1111_0000;
        #1;
        check("alt2_ready", 64'(req_ready), 64'b010);
        check("alt2_rs2",   64'(u_din_rs2), 64'hB000_0001);
        check("alt2_rsp",   64'(rsp_valid), 64'b001);
        check("alt2_rd",    64'(rsp_rd),    64'h1111_0000);
        step();
        u_dout_rd = 32'h1111_0001;
        #1;
        check("alt3_ready", 64'(req_ready), 64'b001);
        check("alt3_rsp",   64'(rsp_valid), 64'b010);
        check("alt3_cnt",   64'(outstanding), 64'd1);
        step();
        u_dout_rd = 32'h1111_0002;
        #1;
        check("alt4_ready", 64'(req_ready), 64'b010);
        check("alt4_rs3",   64'(u_din_rs3), 64'hC000_0001);
        check("alt4_rsp",   64'(rsp_valid), 64'b001);
        step();
        req_valid = '0; u_dout_rd = 32'h1111_0003;
        #1;
        check("alt5_rsp",   64'(rsp_valid), 64'b010);
        step();
        u_dout_valid = 1'b0;
        #1;
        check("alt_done_cnt", 64'(outstanding), 64'd0);

        // Unit stalls results: issue stops at DEPTH outstanding
        req_valid = 3'b011;
        for (int c = 0; c < 10; c++) begin
            step();
        end
        #1;
        check("full_cnt",       64'(outstanding), 64'd4);
        check("full_din_valid", 64'(u_din_valid), 64'd0);
        check("full_req_ready", 64'(req_ready),   64'd0);
        check("full_busy",      64'(busy),        64'd1);
        u_dout_valid = 1'b1; u_dout_rd = 32'h2222_0000;
        #1;
        check("full_pop_rsp",   64'(rsp_valid),   64'b001);
        check("full_pop_block", 64'(u_din_valid), 64'd0);
        step();
        u_dout_rd = 32'h2222_0001;
        #1;
        check("resume_din",   64'(u_din_valid), 64'd1);
        check("resume_ready", 64'(req_ready),   64'b001);
        check("resume_rsp",   64'(rsp_valid),   64'b010);
        step();
        req_valid = '0;
        #1;
        check("drain_cnt",  64'(outstanding), 64'd3);
        check("drain0_rsp", 64'(rsp_valid), 64'b001);
        step();
        #1;
        check("drain1_rsp", 64'(rsp_valid), 64'b010);
        step();
        #1;
        check("drain2_rsp", 64'(rsp_valid), 64'b001);
        step();
        u_dout_valid = 1'b0;
        #1;
        check("drain_done", 64'(outstanding), 64'd0);

        // Three-way rotation from rr_ptr = 0
        reset = 1'b0;
        step();
        reset = 1'b1;
        req_valid = 3'b010;
        #1;
        check("rr_only1_ready", 64'(req_ready),  64'b010);
        check("rr_only1_rs1",   64'(u_din_rs1),  64'hA000_0001);
        check("rr_only1_insn",  64'(u_din_insn), 64'h1A1);
        step();
        req_valid = 3'b101;
        #1;
        check("rr_2_ready", 64'(req_ready), 64'b100);
        check("rr_2_rs1",   64'(u_din_rs1), 64'hA000_0002);
        step();
        #1;
        check("rr_0_ready", 64'(req_ready), 64'b001);
        step();
        req_valid = '0;
        #1;
        check("rr_cnt", 64'(outstanding), 64'd3);

        // Requester-side backpressure on the head result (tag 1)
        u_dout_valid = 1'b1; u_dout_rd = 32'hD00D_0001; rsp_ready = 3'b101;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_dout_ready", 64'(u_dout_ready), 64'd0);
            check("stall_rsp_valid",  64'(rsp_valid),    64'b010);
            check("stall_rd",         64'(rsp_rd),       64'hD00D_0001);
            step();
        end
        check("stall_cnt", 64'(outstanding), 64'd3);
        rsp_ready = '1;
        #1;
        check("stall_release", 64'(u_dout_ready), 64'd1);
        step();

        // hold with two outstanding: results drain, no issue until release
        hold = 1'b1; req_valid = 3'b001; u_dout_rd = 32'hE000_0002;
        #1;
        check("hold_din_valid", 64'(u_din_valid), 64'd0);
        check("hold_req_ready", 64'(req_ready),   64'd0);
        check("hold_rsp2",      64'(rsp_valid),   64'b100);
        step();
        #1;
        check("hold_rsp0", 64'(rsp_valid), 64'b001);
        step();
        u_dout_valid = 1'b0;
        #1;
        check("hold_busy",  64'(busy),        64'd0);
        check("hold_still", 64'(u_din_valid), 64'd0);
        hold = 1'b0;
        #1;
        check("unhold_din",   64'(u_din_valid), 64'd1);
        check("unhold_ready", 64'(req_ready),   64'b001);
        step();
        req_valid = 3'b011;
        #1;
        check("unhold_next", 64'(req_ready), 64'b010);
        step();
        step();
        req_valid = '0;
        #1;
        check("pre_rst_cnt", 64'(outstanding), 64'd3);

        // Reset with ops in flight; the late unit result becomes an orphan
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("mid_rst_cnt",    64'(outstanding), 64'd0);
        check("mid_rst_orphan", 64'(err_orphan),  64'd0);
        u_dout_valid = 1'b1; u_dout_rd = 32'hF00F_0000;
        #1;
        check("orphan_rsp_valid",  64'(rsp_valid),    64'd0);
        check("orphan_dout_ready", 64'(u_dout_ready), 64'd1);
        step();
        u_dout_valid = 1'b0;
        #1;
        check("orphan_flag", 64'(err_orphan),  64'd1);
        check("orphan_cnt",  64'(outstanding), 64'd0);
        step();
        #1;
        check("orphan_sticky", 64'(err_orphan), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
